// File: rtl/stopwatch_lap.sv
// stopwatch_lap: multi-digit BCD stopwatch with prescaler, edge-detected
// start/stop/lap buttons and a circular lap memory readable on the display bus.
module stopwatch_lap #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int LAPS     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sw1,
  input  logic                       sw2,
  input  logic                       sw3,
  input  logic                       view,
  input  logic [$clog2(LAPS)-1:0]    sel,
  output logic [4*DIGITS-1:0]        dsp,
  output logic                       running,
  output logic [$clog2(LAPS+1)-1:0]  lap_cnt,
  output logic                       ovf
);

  localparam int W  = 4 * DIGITS;
  localparam int SW = $clog2(LAPS);
  localparam int LW = $clog2(LAPS + 1);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_LAP, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [2:0]      btn, btn_prev_q, btn_prev_d, ev;
  logic [PW-1:0]   pre_q, pre_d;
  logic [W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [W-1:0]    disp_q, disp_d;
  logic [W-1:0]    dsp_q, dsp_d;
  logic [W-1:0]    lap_mem_q [LAPS];
  logic [W-1:0]    lap_mem_d [LAPS];
  logic [SW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]   lap_cnt_q, lap_cnt_d;
  logic            ovf_q, ovf_d;
  logic            active, tick, carry, all_nines, capture, clear;

  // Button levels packed as {sw3, sw2, sw1}
  assign btn     = {sw3, sw2, sw1};
  assign active  = (state_q == S_COUNT) || (state_q == S_LAP);
  assign tick    = active && (pre_q == PW'(PRESCALE - 1));
  assign running = active;
  assign dsp     = dsp_q;
  assign lap_cnt = lap_cnt_q;
  assign ovf     = ovf_q;

  // Edge detection and next-state decode; stop beats start beats lap/clear
  always_comb begin
    btn_prev_d = btn;
    ev         = btn & ~btn_prev_q;
    state_d    = state_q;
    capture    = 1'b0;
    clear      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!ev[1] && ev[0]) state_d = S_COUNT;
      end
      S_COUNT: begin
        if (ev[1]) begin
          state_d = S_STOP;
        end else if (!ev[0] && ev[2]) begin
          state_d = S_LAP;
          capture = 1'b1;
        end
      end
      S_LAP: begin
        if (ev[1])      state_d = S_STOP;
        else if (ev[0]) state_d = S_COUNT;
        else if (ev[2]) capture = 1'b1;
      end
      S_STOP: begin
        if (ev[1]) begin
          state_d = S_STOP;
        end else if (ev[0]) begin
          state_d = S_COUNT;
        end else if (ev[2]) begin
          state_d = S_IDLE;
          clear   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // BCD increment with ripple carry; a surviving carry means all digits were 9
  always_comb begin
    carry   = 1'b1;
    cnt_inc = cnt_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (cnt_q[4*i +: 4] == 4'd9) begin
          cnt_inc[4*i +: 4] = 4'd0;
        end else begin
          cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    all_nines = carry;
  end

  // Datapath: prescaler, count, display register, lap memory, output mux
  always_comb begin
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    disp_d    = disp_q;
    lap_mem_d = lap_mem_q;
    wr_ptr_d  = wr_ptr_q;
    lap_cnt_d = lap_cnt_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        pre_d  = '0;
        disp_d = '0;
      end
      S_COUNT: begin
        pre_d  = tick ? '0 : pre_q + PW'(1);
        disp_d = cnt_q;
      end
      S_LAP: begin
        pre_d  = tick ? '0 : pre_q + PW'(1);
      end
      default: begin
        disp_d = cnt_q;
      end
    endcase

    if (tick) begin
      cnt_d = cnt_inc;
      if (all_nines) ovf_d = 1'b1;
    end

    // Capture uses the pre-increment count even when a tick coincides
    if (capture) begin
      lap_mem_d[wr_ptr_q] = cnt_q;
      disp_d              = cnt_q;
      wr_ptr_d            = (wr_ptr_q == SW'(LAPS - 1)) ? '0 : wr_ptr_q + SW'(1);
      if (lap_cnt_q != LW'(LAPS)) lap_cnt_d = lap_cnt_q + LW'(1);
    end

    if (clear) begin
      pre_d     = '0;
      cnt_d     = '0;
      disp_d    = '0;
      lap_mem_d = '{default: '0};
      wr_ptr_d  = '0;
      lap_cnt_d = '0;
      ovf_d     = 1'b0;
    end

    if (view) dsp_d = (32'(sel) < 32'(LAPS)) ? lap_mem_q[sel] : '0;
    else      dsp_d = disp_q;
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      btn_prev_q <= '0;
      pre_q      <= '0;
      cnt_q      <= '0;
      disp_q     <= '0;
      dsp_q      <= '0;
      lap_mem_q  <= '{default: '0};
      wr_ptr_q   <= '0;
      lap_cnt_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_prev_q <= btn_prev_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      dsp_q      <= dsp_d;
      lap_mem_q  <= lap_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      lap_cnt_q  <= lap_cnt_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule
